// File: rtl/datapath_pipe_if.sv
// Command/result bundle for datapath_pipe: the controller drives a command and observes
// the busy/done handshake plus the C and status registers.
interface datapath_pipe_if #(
    parameter int W   = 16,
    parameter int PCW = 8,
    parameter int RW  = 3
);
    logic           start;
    logic [RW-1:0]  anum;
    logic [RW-1:0]  bnum;
    logic [RW-1:0]  writenum;
    logic [1:0]     ALUop;
    logic [1:0]     shift;
    logic           asel;
    logic           bsel;
    logic [1:0]     vsel;
    logic           loads;
    logic           write;
    logic [W-1:0]   imm;
    logic [PCW-1:0] PC;
    logic [W-1:0]   mdata;
    logic           busy;
    logic           done;
    logic [W-1:0]   datapath_out;
    logic [2:0]     status_out;

    modport master (
        output start, anum, bnum, writenum, ALUop, shift, asel, bsel,
               vsel, loads, write, imm, PC, mdata,
        input  busy, done, datapath_out, status_out
    );

    modport slave (
        input  start, anum, bnum, writenum, ALUop, shift, asel, bsel,
               vsel, loads, write, imm, PC, mdata,
        output busy, done, datapath_out, status_out
    );
endinterface

// File: rtl/datapath_pipe.sv
// Multi-cycle register-file datapath: IDLE -> READ -> EXEC -> WB, one command at a time.
// Command fields are captured on acceptance; PC and mdata are taken live in WB.
module datapath_pipe #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int PCW  = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    datapath_pipe_if.slave    bus
);
    // state | meaning
    // IDLE  | waiting for start, command fields captured on acceptance
    // READ  | A <= R[anum], B <= R[bnum]
    // EXEC  | C <= ALU result, status updated when loads was captured
    // WB    | done pulse, optional write of R[writenum]
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t         state_q, state_d;

    logic [RW-1:0]  anum_q, anum_d;
    logic [RW-1:0]  bnum_q, bnum_d;
    logic [RW-1:0]  writenum_q, writenum_d;
    logic [1:0]     aluop_q, aluop_d;
    logic [1:0]     shift_q, shift_d;
    logic           asel_q, asel_d;
    logic           bsel_q, bsel_d;
    logic [1:0]     vsel_q, vsel_d;
    logic           loads_q, loads_d;
    logic           write_q, write_d;
    logic [W-1:0]   imm_q, imm_d;

    logic [W-1:0]   regs_q [NREG];
    logic [W-1:0]   regs_d [NREG];
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   c_q, c_d;
    logic [2:0]     status_q, status_d;

    logic [W-1:0]   b_shifted;
    logic [W-1:0]   a_op;
    logic [W-1:0]   b_op;
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [W-1:0]   alu_res;
    logic           alu_v;
    logic [2:0]     alu_status;
    logic [W-1:0]   pc_ext;
    logic [W-1:0]   wb_data;

    always_comb begin
        b_shifted = b_q;
        case (shift_q)
            2'b01:   b_shifted = {b_q[W-2:0], 1'b0};
            2'b10:   b_shifted = {1'b0, b_q[W-1:1]};
            2'b11:   b_shifted = {b_q[W-1], b_q[W-1:1]};
            default: b_shifted = b_q;
        endcase

        a_op = asel_q ? '0 : a_q;
        b_op = bsel_q ? imm_q : b_shifted;
        sum  = a_op + b_op;
        diff = a_op - b_op;

        alu_res = sum;
        alu_v   = 1'b0;
        case (aluop_q)
            2'b00: begin
                alu_res = sum;
                alu_v   = (a_op[W-1] == b_op[W-1]) && (sum[W-1] != a_op[W-1]);
            end
            2'b01: begin
                alu_res = diff;
                alu_v   = (a_op[W-1] != b_op[W-1]) && (diff[W-1] != a_op[W-1]);
            end
            2'b10:   alu_res = a_op & b_op;
            default: alu_res = ~b_op;
        endcase

        alu_status = {alu_res[W-1], alu_v, (alu_res == '0)};
    end

    always_comb begin
        pc_ext           = '0;
        pc_ext[PCW-1:0]  = bus.PC;
        case (vsel_q)
            2'b01:   wb_data = pc_ext;
            2'b10:   wb_data = imm_q;
            2'b11:   wb_data = bus.mdata;
            default: wb_data = c_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        anum_d     = anum_q;
        bnum_d     = bnum_q;
        writenum_d = writenum_q;
        aluop_d    = aluop_q;
        shift_d    = shift_q;
        asel_d     = asel_q;
        bsel_d     = bsel_q;
        vsel_d     = vsel_q;
        loads_d    = loads_q;
        write_d    = write_q;
        imm_d      = imm_q;
        regs_d     = regs_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        status_d   = status_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = READ;
                    anum_d     = bus.anum;
                    bnum_d     = bus.bnum;
                    writenum_d = bus.writenum;
                    aluop_d    = bus.ALUop;
                    shift_d    = bus.shift;
                    asel_d     = bus.asel;
                    bsel_d     = bus.bsel;
                    vsel_d     = bus.vsel;
                    loads_d    = bus.loads;
                    write_d    = bus.write;
                    imm_d      = bus.imm;
                end
            end
            READ: begin
                a_d     = regs_q[anum_q];
                b_d     = regs_q[bnum_q];
                state_d = EXEC;
            end
            EXEC: begin
                c_d = alu_res;
                if (loads_q) begin
                    status_d = alu_status;
                end
                state_d = WB;
            end
            WB: begin
                if (write_q) begin
                    regs_d[writenum_q] = wb_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            anum_q     <= '0;
            bnum_q     <= '0;
            writenum_q <= '0;
            aluop_q    <= '0;
            shift_q    <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            vsel_q     <= '0;
            loads_q    <= 1'b0;
            write_q    <= 1'b0;
            imm_q      <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            anum_q     <= anum_d;
            bnum_q     <= bnum_d;
            writenum_q <= writenum_d;
            aluop_q    <= aluop_d;
            shift_q    <= shift_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            vsel_q     <= vsel_d;
            loads_q    <= loads_d;
            write_q    <= write_d;
            imm_q      <= imm_d;
            regs_q     <= regs_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            status_q   <= status_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == WB);
    assign bus.datapath_out = c_q;
    assign bus.status_out   = status_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe at W=16/NREG=8 and W=32/NREG=16.
module tb_datapath_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    datapath_pipe_if #(.W(16), .PCW(8), .RW(3)) b16 ();
    datapath_pipe_if #(.W(32), .PCW(8), .RW(4)) b32 ();

    datapath_pipe #(.W(16), .NREG(8), .PCW(8)) u16 (
        .clk(clk), .reset_n(reset_n), .bus(b16.slave));
    datapath_pipe #(.W(32), .NREG(16), .PCW(8)) u32 (
        .clk(clk), .reset_n(reset_n), .bus(b32.slave));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set16(input int an, input int bn, input int wn, input int op, input int sh,
                         input int as, input int bs, input int vs, input int ld, input int wr,
                         input logic [15:0] im);
        b16.anum = 3'(an); b16.bnum = 3'(bn); b16.writenum = 3'(wn);
        b16.ALUop = 2'(op); b16.shift = 2'(sh); b16.asel = 1'(as); b16.bsel = 1'(bs);
        b16.vsel = 2'(vs); b16.loads = 1'(ld); b16.write = 1'(wr); b16.imm = im;
    endtask

    task automatic cmd16(input int an, input int bn, input int wn, input int op, input int sh,
                         input int as, input int bs, input int vs, input int ld, input int wr,
                         input logic [15:0] im);
        set16(an, bn, wn, op, sh, as, bs, vs, ld, wr, im);
        b16.start = 1'b1;
        @(posedge clk);
        #1 b16.start = 1'b0;
    endtask

    // Called in the cycle after acceptance; returns at the negedge of the IDLE cycle after WB.
    task automatic wait_done16(input string tag);
        int lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (b16.done) lat = k;
        end
        chk({tag, " latency"}, 32'(lat), 32'd3);
        @(negedge clk);
    endtask

    task automatic rd16(input int idx, input logic [15:0] exp, input string tag);
        cmd16(0, idx, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        wait_done16(tag);
        chk(tag, 32'(b16.datapath_out), 32'(exp));
    endtask

    task automatic cmd32(input int bn, input int wn, input int as, input int bs, input int vs,
                         input int wr, input logic [31:0] im);
        b32.anum = 4'd0; b32.bnum = 4'(bn); b32.writenum = 4'(wn);
        b32.ALUop = 2'd0; b32.shift = 2'd0; b32.asel = 1'(as); b32.bsel = 1'(bs);
        b32.vsel = 2'(vs); b32.loads = 1'b0; b32.write = 1'(wr); b32.imm = im;
        b32.start = 1'b1;
        @(posedge clk);
        #1 b32.start = 1'b0;
    endtask

    task automatic wait_done32(input string tag);
        int lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (b32.done) lat = k;
        end
        chk({tag, " latency"}, 32'(lat), 32'd3);
        @(negedge clk);
    endtask

    task automatic rd32(input int idx, input logic [31:0] exp, input string tag);
        cmd32(idx, 0, 1, 0, 0, 0, 32'h0);
        wait_done32(tag);
        chk(tag, b32.datapath_out, exp);
    endtask

    initial begin
        int ndone, d1, d2;
        b16.start = 1'b0; b16.PC = 8'h00; b16.mdata = 16'h0000;
        set16(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        b32.start = 1'b0; b32.PC = 8'h00; b32.mdata = 32'h0;
        b32.anum = '0; b32.bnum = '0; b32.writenum = '0; b32.ALUop = '0; b32.shift = '0;
        b32.asel = 1'b0; b32.bsel = 1'b0; b32.vsel = '0; b32.loads = 1'b0; b32.write = 1'b0;
        b32.imm = '0;

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(b16.busy), 32'd0);
        chk("rst done", 32'(b16.done), 32'd0);
        chk("rst dout", 32'(b16.datapath_out), 32'h0);
        chk("rst status", 32'(b16.status_out), 32'h0);
        chk("rst dout32", b32.datapath_out, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // R1 = 5, R2 = 0x7FFF, R4 = 0x8002 via immediates
        cmd16(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 16'h0005);
        chk("imm busy", 32'(b16.busy), 32'd1);
        wait_done16("imm5");
        chk("imm5 dout", 32'(b16.datapath_out), 32'h0005);
        cmd16(0, 0, 2, 0, 0, 1, 1, 0, 0, 1, 16'h7FFF);
        wait_done16("imm7fff");
        cmd16(0, 0, 4, 0, 0, 1, 1, 0, 0, 1, 16'h8002);
        wait_done16("imm8002");
        rd16(1, 16'h0005, "rd R1");

        cmd16(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        wait_done16("add ovf");
        chk("add ovf dout", 32'(b16.datapath_out), 32'h8004);
        chk("add ovf status", 32'(b16.status_out), 32'b110);

        cmd16(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0);
        wait_done16("sub zero");
        chk("sub zero dout", 32'(b16.datapath_out), 32'h0000);
        chk("sub zero status", 32'(b16.status_out), 32'b001);

        cmd16(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        wait_done16("add noload");
        chk("add noload dout", 32'(b16.datapath_out), 32'h8004);
        chk("status hold", 32'(b16.status_out), 32'b001);

        cmd16(0, 4, 0, 0, 3, 1, 0, 0, 0, 0, 16'h0);
        wait_done16("asr");
        chk("asr dout", 32'(b16.datapath_out), 32'hC001);
        cmd16(0, 4, 0, 0, 2, 1, 0, 0, 0, 0, 16'h0);
        wait_done16("lsr");
        chk("lsr dout", 32'(b16.datapath_out), 32'h4001);
        cmd16(0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0);
        wait_done16("lsl");
        chk("lsl dout", 32'(b16.datapath_out), 32'h0004);

        cmd16(0, 0, 0, 3, 0, 0, 1, 0, 1, 0, 16'h00FF);
        wait_done16("not");
        chk("not dout", 32'(b16.datapath_out), 32'hFF00);
        chk("not status", 32'(b16.status_out), 32'b100);

        cmd16(2, 4, 0, 2, 0, 0, 0, 0, 1, 0, 16'h0);
        wait_done16("and");
        chk("and dout", 32'(b16.datapath_out), 32'h0002);
        chk("and status", 32'(b16.status_out), 32'b000);

        cmd16(4, 2, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0);
        wait_done16("sub ovf");
        chk("sub ovf dout", 32'(b16.datapath_out), 32'h0003);
        chk("sub ovf status", 32'(b16.status_out), 32'b010);

        // vsel=10 writes imm while C holds R2+imm
        cmd16(2, 0, 7, 0, 0, 0, 1, 2, 0, 1, 16'h0ABC);
        wait_done16("vsel imm");
        chk("vsel imm dout", 32'(b16.datapath_out), 32'h8ABB);
        rd16(7, 16'h0ABC, "rd R7");

        // mdata changes after acceptance; the WB-cycle value must be written
        cmd16(0, 0, 6, 0, 0, 1, 1, 3, 0, 1, 16'h0001);
        b16.mdata = 16'hBEEF;
        wait_done16("vsel mdata");
        rd16(6, 16'hBEEF, "rd R6");

        // inputs change after acceptance and must not affect the command
        cmd16(0, 0, 5, 0, 0, 1, 1, 0, 0, 1, 16'h0011);
        set16(2, 2, 6, 3, 1, 0, 0, 3, 1, 1, 16'hFFFF);
        wait_done16("latch");
        chk("latch dout", 32'(b16.datapath_out), 32'h0011);
        rd16(5, 16'h0011, "rd R5");
        rd16(6, 16'hBEEF, "rd R6 kept");

        // start held for 6 cycles
        set16(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0007);
        b16.start = 1'b1;
        ndone = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 6) b16.start = 1'b0;
            if (b16.done) begin
                ndone++;
                if (ndone == 1) d1 = k;
                else d2 = k;
            end
        end
        chk("held done count", 32'(ndone), 32'd2);
        chk("held first done", 32'(d1), 32'd3);
        chk("held second done", 32'(d2), 32'd7);

        // reset dominates start
        set16(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 16'h0055);
        b16.start = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst vs start busy", 32'(b16.busy), 32'd0);
        b16.start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst vs start dout", 32'(b16.datapath_out), 32'h0);
        rd16(1, 16'h0000, "rd R1 after rst");

        // reset during EXEC aborts the R3 write
        cmd16(0, 0, 3, 0, 0, 1, 1, 0, 1, 1, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(b16.busy), 32'd0);
        chk("abort done", 32'(b16.done), 32'd0);
        reset_n = 1'b1;
        rd16(3, 16'h0000, "rd R3 aborted");
        chk("abort status", 32'(b16.status_out), 32'b000);

        // W=32, NREG=16
        b32.PC = 8'h11;
        cmd32(0, 9, 1, 1, 1, 1, 32'h0);
        b32.PC = 8'hAB;
        wait_done32("pc32");
        rd32(9, 32'h0000_00AB, "rd32 R9");
        cmd32(0, 15, 1, 1, 0, 1, 32'hFFFF_FFFF);
        wait_done32("imm32");
        chk("imm32 dout", b32.datapath_out, 32'hFFFF_FFFF);
        rd32(15, 32'hFFFF_FFFF, "rd32 R15");
        cmd32(0, 3, 1, 1, 0, 1, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort32 busy", 32'(b32.busy), 32'd0);
        reset_n = 1'b1;
        rd32(3, 32'h0, "rd32 R3 aborted");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
